// File: rtl/rx_vector_assembler.sv
// rx_vector_assembler: gathers per-antenna IQ samples into one vector per
// MIMO symbol and queues finished vectors for the downstream detector.
// The arrival order is checked. Out-of-order and bad-configuration samples
// are reported and dropped.
module rx_vector_assembler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  sample_in,
  input  logic [2:0]   sample_ant,
  input  logic         sample_valid,
  output logic         sample_ready,
  input  logic [2:0]   mimo_config,
  output logic [255:0] vec_data,
  output logic [3:0]   vec_num_ant,
  output logic         vec_valid,
  input  logic         vec_ready,
  output logic         order_err,
  output logic         cfg_err,
  output logic [7:0]   err_cnt,
  output logic [2:0]   fifo_level
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic {
    S_EXPECT0 = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t             r_state;
  logic [2:0]         r_exp_idx;
  logic [3:0]         r_n;
  logic [255:0]       r_vec;
  logic               r_order_err;
  logic               r_cfg_err;
  logic [7:0]         r_err_cnt;

  logic [255:0]       r_fifo_data [FIFO_DEPTH];
  logic [3:0]         r_fifo_nant [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LVL_W-1:0]   r_level;

  logic               w_xfer;
  logic               w_pop;
  logic               w_rsv;
  logic               w_start;
  logic               w_store;
  logic               w_push;
  logic               w_order_err;
  logic               w_cfg_err;
  logic [3:0]         w_cfg_n;
  logic [3:0]         w_push_nant;
  logic [255:0]       w_vec;
  logic [7:0]         w_lane_lsb;

  // Accepting is allowed whenever a slot is free now or one frees at this
  // edge. A push into a full FIFO therefore always coincides with a pop.
  assign vec_valid    = (r_level != '0);
  assign sample_ready = (r_level < LVL_W'(FIFO_DEPTH)) || vec_ready;
  assign w_xfer       = sample_valid && sample_ready;
  assign w_pop        = vec_valid && vec_ready;
  assign w_rsv        = mimo_config[2];
  assign w_cfg_n      = 4'd1 << mimo_config[1:0];
  assign w_lane_lsb   = {sample_ant, 5'b0_0000};

  assign vec_data     = vec_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign vec_num_ant  = vec_valid ? r_fifo_nant[r_rd_ptr] : '0;
  assign order_err    = r_order_err;
  assign cfg_err      = r_cfg_err;
  assign err_cnt      = r_err_cnt;
  assign fifo_level   = 3'(r_level);

  // Classify the accepted sample. Build the updated vector and decide whether it completes.
  always_comb begin
    w_start     = 1'b0;
    w_store     = 1'b0;
    w_push      = 1'b0;
    w_order_err = 1'b0;
    w_cfg_err   = 1'b0;
    w_vec       = r_vec;
    w_push_nant = r_n;
    if (w_xfer) begin
      if (r_state == S_EXPECT0) begin
        if (w_rsv) begin
          w_cfg_err = 1'b1;
        end else if (sample_ant != 3'd0) begin
          w_order_err = 1'b1;
        end else begin
          w_start = 1'b1;
        end
      end else if (sample_ant == r_exp_idx) begin
        w_store = 1'b1;
      end else begin
        // The partial vector is abandoned. Antenna 0 with a usable config restarts at once.
        w_order_err = 1'b1;
        if ((sample_ant == 3'd0) && !w_rsv) begin
          w_start = 1'b1;
        end
      end
    end
    if (w_start) begin
      w_vec        = '0;
      w_vec[31:0]  = sample_in;
      w_push_nant  = w_cfg_n;
      w_push       = (w_cfg_n == 4'd1);
    end else if (w_store) begin
      w_vec[w_lane_lsb +: 32] = sample_in;
      w_push = ({1'b0, r_exp_idx} == (r_n - 4'd1));
    end
  end

  // Assembly FSM with registered error pulses and saturating error counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_EXPECT0;
      r_exp_idx   <= 3'd0;
      r_n         <= 4'd0;
      r_order_err <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_order_err <= w_order_err;
      r_cfg_err   <= w_cfg_err;
      if ((w_order_err || w_cfg_err) && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (w_start) begin
        r_n       <= w_cfg_n;
        r_exp_idx <= 3'd1;
        r_state   <= w_push ? S_EXPECT0 : S_COLLECT;
      end else if (w_store) begin
        r_exp_idx <= r_exp_idx + 3'd1;
        if (w_push) begin
          r_state <= S_EXPECT0;
        end
      end else if (w_order_err) begin
        r_state <= S_EXPECT0;
      end
    end
  end

  // Partial-vector lanes. No reset is needed because a new vector always clears them on start.
  always_ff @(posedge clk) begin
    if (w_start || w_store) begin
      r_vec <= w_vec;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // FIFO storage. The output is gated to zero while empty, so the contents need no reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= w_vec;
      r_fifo_nant[r_wr_ptr] <= w_push_nant;
    end
  end

endmodule

// File: tb/tb_rx_vector_assembler.sv
// Bench for rx_vector_assembler: a queue-based reference model predicts
// vectors and error pulses. A monitor compares them against the DUT outputs.
module tb_rx_vector_assembler;

  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  sample_in;
  logic [2:0]   sample_ant;
  logic         sample_valid;
  logic         sample_ready;
  logic [2:0]   mimo_config;
  logic [255:0] vec_data;
  logic [3:0]   vec_num_ant;
  logic         vec_valid;
  logic         vec_ready;
  logic         order_err;
  logic         cfg_err;
  logic [7:0]   err_cnt;
  logic [2:0]   fifo_level;

  rx_vector_assembler #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_ant   (sample_ant),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .mimo_config  (mimo_config),
    .vec_data     (vec_data),
    .vec_num_ant  (vec_num_ant),
    .vec_valid    (vec_valid),
    .vec_ready    (vec_ready),
    .order_err    (order_err),
    .cfg_err      (cfg_err),
    .err_cnt      (err_cnt),
    .fifo_level   (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] data;
    logic [3:0]   nant;
  } vec_t;

  typedef struct {
    int kind;
    int cnt;
    bit rst;
  } err_t;

  vec_t        sbq[$];
  err_t        errq[$];
  logic [31:0] col[$];
  int          m_n;
  int          ecnt;
  int          total;
  int          bad;
  bit          started;
  bit          g_vr;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference model: the collected lane list is empty while waiting for antenna 0.
  task automatic model_xfer(input logic [2:0] ant, input logic [31:0] d,
                            input logic [2:0] cfg, output int kind);
    bit   rsv;
    vec_t v;
    kind = 0;
    rsv  = (cfg >= 3'd4);
    if (col.size() == 0) begin
      if (rsv) kind = 2;
      else if (ant != 3'd0) kind = 1;
      else begin
        m_n = 1 << int'(cfg);
        col.push_back(d);
      end
    end else if (int'(ant) == col.size()) begin
      col.push_back(d);
    end else begin
      kind = 1;
      col.delete();
      if (ant == 3'd0 && !rsv) begin
        m_n = 1 << int'(cfg);
        col.push_back(d);
      end
    end
    if (col.size() != 0 && col.size() == m_n) begin
      v.data = '0;
      for (int i = 0; i < col.size(); i++) v.data[32*i +: 32] = col[i];
      v.nant = 4'(m_n);
      sbq.push_back(v);
      col.delete();
    end
    if (kind != 0 && ecnt < 255) ecnt++;
  endtask

  task automatic step(input bit v, input logic [2:0] ant, input logic [31:0] d,
                      input logic [2:0] cfg, input bit vr, input bit rst, output bit acc);
    bit exp_rdy;
    int kind;
    err_t e;
    @(negedge clk);
    rst_n        = !rst;
    sample_valid = v;
    sample_ant   = ant;
    sample_in    = d;
    mimo_config  = cfg;
    vec_ready    = vr;
    #1;
    exp_rdy = (sbq.size() < DEPTH) || vr;
    chk("sample_ready", sample_ready, exp_rdy);
    acc = v && exp_rdy && !rst;
    @(posedge clk);
    #1;
    if (rst) begin
      sbq.delete();
      col.delete();
      ecnt = 0;
      e = '{0, 0, 1'b1};
    end else begin
      kind = 0;
      if (acc) model_xfer(ant, d, cfg, kind);
      e = '{kind, ecnt, 1'b0};
    end
    errq.push_back(e);
    started = 1'b1;
  endtask

  task automatic send(input logic [2:0] ant, input logic [31:0] d, input logic [2:0] cfg);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) step(1'b1, ant, d, cfg, g_vr, 1'b0, acc);
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout ant=%0d got=not_accepted exp=accepted", ant);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd0, 3'd0, g_vr, 1'b0, acc);
  endtask

  task automatic do_reset();
    bit acc;
    step(1'b0, 3'd0, 32'd0, 3'd0, 1'b0, 1'b1, acc);
  endtask

  // Monitor: compare FIFO state, head vector and error pulses once per cycle
  initial begin
    err_t e;
    forever begin
      @(negedge clk);
      #2;
      if (started) begin
        chk("fifo_level", fifo_level, sbq.size());
        chk("vec_valid", vec_valid, sbq.size() != 0);
        if (sbq.size() != 0) begin
          chk("vec_data", vec_data, sbq[0].data);
          chk("vec_num_ant", vec_num_ant, sbq[0].nant);
          if (vec_ready) void'(sbq.pop_front());
        end
        if (errq.size() != 0) begin
          e = errq.pop_front();
          chk("order_err", order_err, e.kind == 1);
          chk("cfg_err", cfg_err, e.kind == 2);
          chk("err_cnt", err_cnt, e.cnt);
          if (e.rst) begin
            chk("reset_vec_data", vec_data, 256'd0);
            chk("reset_vec_num_ant", vec_num_ant, 4'd0);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    logic [2:0] ant;
    logic [2:0] cfg;
    total = 0;
    bad = 0;
    started = 1'b0;
    m_n = 0;
    ecnt = 0;
    g_vr = 1'b1;
    rst_n = 1'b0;
    sample_valid = 1'b0;
    sample_ant = 3'd0;
    sample_in = 32'd0;
    mimo_config = 3'd0;
    vec_ready = 1'b0;

    do_reset();
    do_reset();

    // two-antenna vector, single-cycle latency
    g_vr = 1'b1;
    send(3'd0, 32'h0001_0002, 3'd1);
    send(3'd1, 32'h0003_0004, 3'd1);
    idle(2);

    // eight antennas, config changed mid-vector, then a one-lane vector
    for (int a = 0; a < 8; a++) send(3'(a), $urandom, (a < 4) ? 3'd3 : 3'd0);
    send(3'd0, $urandom, 3'd0);
    idle(2);

    // skipped antenna, then a clean four-antenna vector
    send(3'd0, $urandom, 3'd2);
    send(3'd1, $urandom, 3'd2);
    send(3'd3, $urandom, 3'd2);
    for (int a = 0; a < 4; a++) send(3'(a), $urandom, 3'd2);
    idle(2);

    // fill the FIFO with backpressure, then drain
    g_vr = 1'b0;
    for (int i = 0; i < 4; i++) send(3'd0, $urandom, 3'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 32'hCAFE_0005, 3'd0, 1'b0, 1'b0, acc);
    g_vr = 1'b1;
    send(3'd0, 32'hCAFE_0005, 3'd0);
    idle(8);

    // reserved config errors drive the counter into saturation
    for (int i = 0; i < 300; i++) send(3'd0, $urandom, 3'd5);
    idle(2);

    // reset in the middle of a vector, with vectors queued
    g_vr = 1'b0;
    for (int i = 0; i < 8; i++) send(3'(i % 4), $urandom, 3'd2);
    send(3'd0, $urandom, 3'd2);
    send(3'd1, $urandom, 3'd2);
    do_reset();
    g_vr = 1'b1;
    send(3'd2, $urandom, 3'd2);
    send(3'd3, $urandom, 3'd2);
    idle(4);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        ant = ($urandom_range(0, 7) < 6) ? 3'(col.size() % 8) : 3'($urandom_range(0, 7));
        cfg = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        g_vr = ($urandom_range(0, 2) != 0);
        step($urandom_range(0, 3) != 0, ant, $urandom, cfg, g_vr, 1'b0, acc);
      end
    end

    g_vr = 1'b1;
    idle(10);
    chk("scoreboard_empty", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
